// File: rtl/hex_display_scanner_if.sv
// rtl/hex_display_scanner_if.sv - register bus between host and hex display scanner
interface hex_display_scanner_if;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output wr_en, output addr, output wr_data, input rd_data);
  modport slave  (input wr_en, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - multiplexed hex 7-segment scan controller
// Shares one external hex decoder across digits with dead time, frame shadowing, blanking, blink.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hex_display_scanner_if.slave  bus,
  output logic [3:0]            hex_value,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DEAD = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;

  logic [31:0]           value_q, shadow_q, value_next;
  logic                  en_q, lz_q, blink_q, phase_q;
  logic [7:0]            mask_q;
  logic [1:0]            state_q;
  logic [CW-1:0]         cnt_q;
  logic [2:0]            idx_q;
  logic [FW-1:0]         frame_q;
  logic                  value_wr, ctrl_wr, slot_end, frame_end, blank;
  logic [7:0]            upper_zero;
  logic [NUM_DIGITS-1:0] an_next;

  assign value_wr   = bus.wr_en && (bus.addr == 2'd0);
  assign ctrl_wr    = bus.wr_en && (bus.addr == 2'd1);
  assign value_next = value_wr ? bus.wr_data : value_q;
  assign slot_end   = (state_q == SHOW) && (cnt_q == CW'(REFRESH_DIV - 1));
  assign frame_end  = slot_end && (idx_q == 3'(NUM_DIGITS - 1));
  assign hex_value  = shadow_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      2'd0:    bus.rd_data = value_q;
      2'd1:    bus.rd_data = {16'd0, mask_q, 5'd0, blink_q, lz_q, en_q};
      2'd2:    bus.rd_data = {27'd0, state_q != IDLE, phase_q, idx_q};
      default: bus.rd_data = '0;
    endcase
  end

  // upper_zero[j]: shadow nibbles j..NUM_DIGITS-1 are all zero
  always_comb begin
    logic z;
    z          = 1'b1;
    upper_zero = '0;
    for (int j = 7; j >= 0; j--) begin
      if (j < NUM_DIGITS) begin
        z             = z & (shadow_q[4*j +: 4] == 4'd0);
        upper_zero[j] = z;
      end
    end
  end

  assign blank = mask_q[idx_q]
               | (lz_q && (idx_q != 3'd0) && upper_zero[idx_q])
               | (blink_q && phase_q);

  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((state_q == SHOW) && en_q && !blank && (idx_q == 3'(i)))
        an_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= '0;
      shadow_q <= '0;
      en_q     <= 1'b0;
      lz_q     <= 1'b0;
      blink_q  <= 1'b0;
      mask_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      an_out   <= '1;
      seg_out  <= 7'h7F;
    end else begin
      if (value_wr)
        value_q <= bus.wr_data;
      if (ctrl_wr) begin
        en_q    <= bus.wr_data[0];
        lz_q    <= bus.wr_data[1];
        blink_q <= bus.wr_data[2];
        mask_q  <= bus.wr_data[15:8];
      end

      // anode and segment registered together so a lit digit never shows a stale pattern
      an_out  <= an_next;
      seg_out <= ((state_q == SHOW) && en_q) ? seg_in : 7'h7F;

      if (!en_q) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        frame_q <= '0;
        phase_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= DEAD;
            cnt_q    <= '0;
            shadow_q <= value_next;
          end
          DEAD: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(DEAD_CYCLES - 1))
              state_q <= SHOW;
          end
          SHOW: begin
            if (slot_end) begin
              cnt_q   <= '0;
              state_q <= DEAD;
              idx_q   <= frame_end ? 3'd0 : idx_q + 3'd1;
              if (frame_end) begin
                shadow_q <= value_next;
                if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                  frame_q <= '0;
                  phase_q <= ~phase_q;
                end else begin
                  frame_q <= frame_q + 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner
module tb_hex_display_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] hex_value;
  logic [6:0] seg_in;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  int         checks = 0;
  int         errors = 0;

  hex_display_scanner_if bus ();

  hex_display_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .DEAD_CYCLES (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .hex_value(hex_value),
    .seg_in   (seg_in),
    .seg_out  (seg_out),
    .an_out   (an_out)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  assign seg_in = seg7(hex_value);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.addr  = 2'd2;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.addr = a;
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  // one slot: an anodes-off cycle, then three cycles at an_exp
  task automatic expect_slot(input logic [3:0] an_exp, input logic [3:0] nib,
                             input logic [2:0] digit, input logic phase);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.addr  = 2'd2;
    #1;
    chk($sformatf("dead_an d%0d", digit), an_out, 4'hF);
    chk($sformatf("status d%0d", digit), bus.rd_data, {27'd0, 1'b1, phase, digit});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.addr  = 2'd2;
      #1;
      chk($sformatf("an d%0d", digit), an_out, an_exp);
      if (an_exp != 4'hF)
        chk($sformatf("seg d%0d", digit), seg_out, seg7(nib));
    end
  endtask

  task automatic start_check();
    #1;
    chk("start_an_idle", an_out, 4'hF);
    chk("start_status_idle", bus.rd_data, 32'h0);
    @(negedge clk);
    #1;
    chk("start_an_dead", an_out, 4'hF);
    chk("start_status_dead", bus.rd_data, 32'h10);
  endtask

  task automatic disable_check();
    write_reg(2'd1, 32'h0);
    @(negedge clk);
    #1;
    chk("dis_an", an_out, 4'hF);
    chk("dis_seg", seg_out, 7'h7F);
    chk("dis_status", bus.rd_data, 32'h0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.addr    = 2'd2;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", an_out, 4'hF);
    chk("rst_seg", seg_out, 7'h7F);
    rst_n = 1'b1;

    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      chk("idle_an", an_out, 4'hF);
      chk("idle_seg", seg_out, 7'h7F);
      chk("idle_status", bus.rd_data, 32'h0);
    end
    chk("rst_hex", hex_value, 4'h0);
    rd(2'd0, 32'h0, "rst_value");
    rd(2'd1, 32'h0, "rst_ctrl");
    rd(2'd3, 32'h0, "rst_addr3");

    write_reg(2'd2, 32'hFFFF_FFFF);
    write_reg(2'd3, 32'hFFFF_FFFF);
    rd(2'd2, 32'h0, "status_ro");
    rd(2'd3, 32'h0, "addr3_ro");
    rd(2'd1, 32'h0, "ctrl_untouched");

    // plain scan of 0x1234
    write_reg(2'd0, 32'h0000_1234);
    rd(2'd0, 32'h0000_1234, "value_rb");
    write_reg(2'd1, 32'h0000_0001);
    start_check();
    expect_slot(4'hE, 4'h4, 3'd0, 1'b0);
    expect_slot(4'hD, 4'h3, 3'd1, 1'b0);
    expect_slot(4'hB, 4'h2, 3'd2, 1'b0);
    expect_slot(4'h7, 4'h1, 3'd3, 1'b0);
    expect_slot(4'hE, 4'h4, 3'd0, 1'b0);
    expect_slot(4'hD, 4'h3, 3'd1, 1'b0);
    bus.wr_en   = 1'b1;
    bus.addr    = 2'd0;
    bus.wr_data = 32'h0000_ABCD;
    expect_slot(4'hB, 4'h2, 3'd2, 1'b0);
    expect_slot(4'h7, 4'h1, 3'd3, 1'b0);
    expect_slot(4'hE, 4'hD, 3'd0, 1'b1);
    expect_slot(4'hD, 4'hC, 3'd1, 1'b1);
    expect_slot(4'hB, 4'hB, 3'd2, 1'b1);
    expect_slot(4'h7, 4'hA, 3'd3, 1'b1);
    disable_check();

    // leading-zero blanking, then per-digit mask
    write_reg(2'd0, 32'h0000_0005);
    write_reg(2'd1, 32'h0000_0003);
    start_check();
    expect_slot(4'hE, 4'h5, 3'd0, 1'b0);
    expect_slot(4'hF, 4'h0, 3'd1, 1'b0);
    expect_slot(4'hF, 4'h0, 3'd2, 1'b0);
    expect_slot(4'hF, 4'h0, 3'd3, 1'b0);
    bus.wr_en   = 1'b1;
    bus.addr    = 2'd1;
    bus.wr_data = 32'h0000_0401;
    expect_slot(4'hE, 4'h5, 3'd0, 1'b0);
    expect_slot(4'hD, 4'h0, 3'd1, 1'b0);
    expect_slot(4'hF, 4'h0, 3'd2, 1'b0);
    expect_slot(4'h7, 4'h0, 3'd3, 1'b0);
    rd(2'd1, 32'h0000_0401, "ctrl_mask_rb");
    disable_check();

    // blink: lit for two frames, dark for two, lit again
    write_reg(2'd1, 32'h0000_0005);
    start_check();
    for (int f = 0; f < 5; f++) begin
      for (int d = 0; d < 4; d++) begin
        logic       dark;
        logic [3:0] an_lit;
        dark   = (f == 2) || (f == 3);
        an_lit = 4'hF;
        an_lit[d] = 1'b0;
        expect_slot(dark ? 4'hF : an_lit, (d == 0) ? 4'h5 : 4'h0, 3'(d), dark);
      end
    end

    // asynchronous reset while a digit is lit
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_an", an_out, 4'hE);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", an_out, 4'hF);
    chk("async_rst_seg", seg_out, 7'h7F);
    chk("async_rst_status", bus.rd_data, 32'h0);
    chk("async_rst_hex", hex_value, 4'h0);
    rd(2'd0, 32'h0, "async_rst_value");
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    bus.addr = 2'd2;
    write_reg(2'd0, 32'h0000_1234);
    write_reg(2'd1, 32'h0000_0001);
    start_check();
    expect_slot(4'hE, 4'h4, 3'd0, 1'b0);
    expect_slot(4'hD, 4'h3, 3'd1, 1'b0);
    expect_slot(4'hB, 4'h2, 3'd2, 1'b0);
    expect_slot(4'h7, 4'h1, 3'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
